// File: rtl/sargantana_icache_pkg.sv
// Shared types and tree pseudo-LRU helpers for the icache tag-memory controller.
// The helpers are used only when ITAG_CTRL_PLRU_EN is defined.
package sargantana_icache_pkg;

    localparam int unsigned ICACHE_N_WAY   = 4;
    localparam int unsigned TAG_WIDHT      = 20;
    localparam int unsigned TAG_ADDR_WIDHT = 6;
    localparam int unsigned PLRU_MAX_W     = 63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LKP_CMP,
        ST_REF_RD,
        ST_REF_SEL,
        ST_REF_WR,
        ST_FLUSH,
        ST_FLUSH_DONE
    } itag_ctrl_state_e;

    typedef struct packed {
        logic [TAG_ADDR_WIDHT-1:0] idx;
        logic [TAG_WIDHT-1:0]      tag;
    } itag_lkp_t;

    typedef struct packed {
        logic [TAG_ADDR_WIDHT-1:0] idx;
        logic [TAG_WIDHT-1:0]      tag;
    } itag_ref_t;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a set bit steers toward the right child.
    function automatic int unsigned plru_victim(input logic [PLRU_MAX_W-1:0] tree,
                                                input int unsigned levels);
        int unsigned node;
        node = 0;
        for (int unsigned l = 0; l < levels; l++) begin
            if (tree[node[5:0]]) node = 2 * node + 2;
            else                 node = 2 * node + 1;
        end
        return node - ((32'd1 << levels) - 32'd1);
    endfunction

    function automatic logic [PLRU_MAX_W-1:0] plru_update(input logic [PLRU_MAX_W-1:0] tree,
                                                          input int unsigned way,
                                                          input int unsigned levels);
        logic [PLRU_MAX_W-1:0] t;
        int unsigned node;
        logic dir;
        t    = tree;
        node = 0;
        for (int unsigned l = 0; l < levels; l++) begin
            dir          = ((way >> (levels - 1 - l)) & 32'd1) != 32'd0;
            t[node[5:0]] = ~dir;
            node         = dir ? 2 * node + 2 : 2 * node + 1;
        end
        return t;
    endfunction

endpackage

// File: rtl/sargantana_itag_repl.sv
// Victim selection and replacement-state update for the icache tag controller.
// ITAG_CTRL_PLRU_EN: per-set tree pseudo-LRU; otherwise a single global round-robin pointer.
module sargantana_itag_repl
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned N_WAY = ICACHE_N_WAY,
    parameter int unsigned IDX_W = TAG_ADDR_WIDHT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [IDX_W-1:0] sel_idx_i,
    output logic [N_WAY-1:0] victim_o,
    input  logic             hit_upd_i,
    input  logic [IDX_W-1:0] hit_idx_i,
    input  logic [N_WAY-1:0] hit_way_i,
    input  logic             fill_upd_i,
    input  logic [IDX_W-1:0] fill_idx_i,
    input  logic [N_WAY-1:0] fill_way_i,
    input  logic             fill_from_repl_i
);

    localparam int unsigned WAY_W = $clog2(N_WAY);

`ifdef ITAG_CTRL_PLRU_EN
    logic [N_WAY-2:0]      tree_q [2**IDX_W];
    logic                  upd;
    logic [IDX_W-1:0]      upd_idx;
    logic [N_WAY-1:0]      upd_way;
    logic [PLRU_MAX_W-1:0] upd_tree;
    int unsigned           vic;
    int unsigned           upd_way_idx;

    always_comb begin
        upd         = hit_upd_i | fill_upd_i;
        upd_idx     = fill_upd_i ? fill_idx_i : hit_idx_i;
        upd_way     = fill_upd_i ? fill_way_i : hit_way_i;
        // A multi-hit is an error case; the lowest hitting way is treated as the accessed one.
        upd_way_idx = 0;
        for (int unsigned w = N_WAY; w > 0; w--)
            if (upd_way[w-1]) upd_way_idx = w - 1;
        vic      = plru_victim(PLRU_MAX_W'(tree_q[sel_idx_i]), WAY_W);
        victim_o = N_WAY'(1) << vic;
        upd_tree = plru_update(PLRU_MAX_W'(tree_q[upd_idx]), upd_way_idx, WAY_W);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int unsigned s = 0; s < 2**IDX_W; s++)
                tree_q[s] <= '0;
        end else if (upd) begin
            tree_q[upd_idx] <= upd_tree[N_WAY-2:0];
        end
    end

    logic unused_plru;
    assign unused_plru = ^{fill_from_repl_i, upd_tree[PLRU_MAX_W-1:N_WAY-1]};
`else
    logic [WAY_W-1:0] ptr_q;

    assign victim_o = N_WAY'(1) << ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i)
            ptr_q <= '0;
        else if (fill_upd_i && fill_from_repl_i)
            ptr_q <= ptr_q + WAY_W'(1);
    end

    logic unused_rr;
    assign unused_rr = ^{sel_idx_i, hit_upd_i, hit_idx_i, hit_way_i, fill_idx_i, fill_way_i};
`endif

endmodule

// File: rtl/sargantana_itag_ctrl.sv
// Tag-memory controller: lookup compare, refill read-select-write, and flush sequencing.
// Replacement policy chosen by ITAG_CTRL_PLRU_EN (see sargantana_itag_repl).
module sargantana_itag_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned N_WAY = ICACHE_N_WAY,
    parameter int unsigned TAG_W = TAG_WIDHT,
    parameter int unsigned IDX_W = TAG_ADDR_WIDHT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   lkp_valid_i,
    output logic                   lkp_ready_o,
    input  logic [IDX_W-1:0]       lkp_idx_i,
    input  logic [TAG_W-1:0]       lkp_tag_i,
    output logic                   resp_valid_o,
    output logic                   resp_hit_o,
    output logic [N_WAY-1:0]       resp_way_o,
    output logic                   resp_multi_o,
    input  logic                   ref_valid_i,
    output logic                   ref_ready_o,
    input  logic [IDX_W-1:0]       ref_idx_i,
    input  logic [TAG_W-1:0]       ref_tag_i,
    output logic                   ref_done_o,
    output logic [N_WAY-1:0]       ref_way_o,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic [N_WAY-1:0]       tm_req_o,
    output logic                   tm_we_o,
    output logic                   tm_vbit_o,
    output logic                   tm_flush_o,
    output logic [TAG_W-1:0]       tm_data_o,
    output logic [IDX_W-1:0]       tm_addr_o,
    input  logic [N_WAY*TAG_W-1:0] tm_tag_way_i,
    input  logic [N_WAY-1:0]       tm_vbit_i
);

    itag_ctrl_state_e state_q, state_d;
    logic             flush_pend_q;
    itag_lkp_t        lkp_q;
    itag_ref_t        ref_q;
    logic [N_WAY-1:0] victim_q;
    logic             from_repl_q;
    logic [N_WAY-1:0] hits, inv_ways, first_inv, repl_victim;
    logic             can_take, lkp_fire, ref_fire, in_cmp;

    // New work is only taken in IDLE/LKP_CMP; pending flush outranks refill, which outranks lookup.
    assign can_take    = !rst_i && (state_q == ST_IDLE || state_q == ST_LKP_CMP);
    assign ref_ready_o = can_take && !flush_pend_q;
    assign lkp_ready_o = ref_ready_o && !ref_valid_i;
    assign lkp_fire    = lkp_valid_i && lkp_ready_o;
    assign ref_fire    = ref_valid_i && ref_ready_o;
    assign in_cmp      = !rst_i && state_q == ST_LKP_CMP;

    always_comb begin
        hits = '0;
        for (int unsigned w = 0; w < N_WAY; w++)
            hits[w] = tm_vbit_i[w] && (tm_tag_way_i[w*TAG_W +: TAG_W] == lkp_q.tag[TAG_W-1:0]);
    end

    assign resp_valid_o = in_cmp;
    assign resp_hit_o   = in_cmp && (|hits);
    assign resp_way_o   = in_cmp ? hits : '0;
    assign resp_multi_o = in_cmp && ((hits & (hits - 1'b1)) != '0);

    assign inv_ways  = ~tm_vbit_i;
    assign first_inv = inv_ways & (~inv_ways + 1'b1);

    assign ref_done_o   = !rst_i && state_q == ST_REF_WR;
    assign ref_way_o    = ref_done_o ? victim_q : '0;
    assign flush_done_o = !rst_i && state_q == ST_FLUSH_DONE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_LKP_CMP: begin
                if (flush_pend_q)  state_d = ST_FLUSH;
                else if (ref_fire) state_d = ST_REF_RD;
                else if (lkp_fire) state_d = ST_LKP_CMP;
                else               state_d = ST_IDLE;
            end
            ST_REF_RD:     state_d = ST_REF_SEL;
            ST_REF_SEL:    state_d = ST_REF_WR;
            ST_REF_WR:     state_d = ST_IDLE;
            ST_FLUSH:      state_d = ST_FLUSH_DONE;
            ST_FLUSH_DONE: state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tm_req_o   = '0;
        tm_we_o    = 1'b0;
        tm_vbit_o  = 1'b0;
        tm_flush_o = 1'b0;
        tm_data_o  = '0;
        tm_addr_o  = '0;
        if (lkp_fire) begin
            tm_req_o  = '1;
            tm_addr_o = lkp_idx_i;
        end
        if (!rst_i) begin
            case (state_q)
                ST_REF_RD: begin
                    tm_req_o  = '1;
                    tm_addr_o = ref_q.idx[IDX_W-1:0];
                end
                ST_REF_WR: begin
                    tm_req_o  = victim_q;
                    tm_we_o   = 1'b1;
                    tm_vbit_o = 1'b1;
                    tm_data_o = ref_q.tag[TAG_W-1:0];
                    tm_addr_o = ref_q.idx[IDX_W-1:0];
                end
                ST_FLUSH: tm_flush_o = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            flush_pend_q <= 1'b0;
            lkp_q        <= '0;
            ref_q        <= '0;
            victim_q     <= '0;
            from_repl_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= (state_q == ST_FLUSH) ? flush_i : (flush_pend_q | flush_i);
            if (lkp_fire)
                lkp_q <= '{idx: TAG_ADDR_WIDHT'(lkp_idx_i), tag: TAG_WIDHT'(lkp_tag_i)};
            if (ref_fire)
                ref_q <= '{idx: TAG_ADDR_WIDHT'(ref_idx_i), tag: TAG_WIDHT'(ref_tag_i)};
            if (state_q == ST_REF_SEL) begin
                victim_q    <= (inv_ways != '0) ? first_inv : repl_victim;
                from_repl_q <= (inv_ways == '0);
            end
        end
    end

    sargantana_itag_repl #(
        .N_WAY (N_WAY),
        .IDX_W (IDX_W)
    ) u_repl (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clear_i          (!rst_i && state_q == ST_FLUSH),
        .sel_idx_i        (ref_q.idx[IDX_W-1:0]),
        .victim_o         (repl_victim),
        .hit_upd_i        (resp_hit_o),
        .hit_idx_i        (lkp_q.idx[IDX_W-1:0]),
        .hit_way_i        (hits),
        .fill_upd_i       (ref_done_o),
        .fill_idx_i       (ref_q.idx[IDX_W-1:0]),
        .fill_way_i       (victim_q),
        .fill_from_repl_i (from_repl_q)
    );

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Self-checking bench for sargantana_itag_ctrl (default round-robin build, N_WAY=4).
// Includes a behavioural tag memory and an independent set/valid/round-robin reference model.
module tb_sargantana_itag_ctrl;

    localparam int NW = 4;
    localparam int TW = 20;
    localparam int IW = 6;
    localparam int NS = 64;

    logic clk = 1'b0;
    logic rst;
    logic lkp_valid, lkp_ready, ref_valid, ref_ready;
    logic [IW-1:0] lkp_idx, ref_idx, tm_addr;
    logic [TW-1:0] lkp_tag, ref_tag, tm_data;
    logic resp_valid, resp_hit, resp_multi, ref_done, flush, flush_done;
    logic [NW-1:0] resp_way, ref_way, tm_req, rd_v;
    logic tm_we, tm_vbit, tm_flush;
    logic [NW*TW-1:0] rd_tag;

    always #5 clk = ~clk;

    sargantana_itag_ctrl #(.N_WAY(NW), .TAG_W(TW), .IDX_W(IW)) dut (
        .clk_i(clk), .rst_i(rst),
        .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_idx_i(lkp_idx), .lkp_tag_i(lkp_tag),
        .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_way_o(resp_way), .resp_multi_o(resp_multi),
        .ref_valid_i(ref_valid), .ref_ready_o(ref_ready), .ref_idx_i(ref_idx), .ref_tag_i(ref_tag),
        .ref_done_o(ref_done), .ref_way_o(ref_way),
        .flush_i(flush), .flush_done_o(flush_done),
        .tm_req_o(tm_req), .tm_we_o(tm_we), .tm_vbit_o(tm_vbit), .tm_flush_o(tm_flush),
        .tm_data_o(tm_data), .tm_addr_o(tm_addr),
        .tm_tag_way_i(rd_tag), .tm_vbit_i(rd_v)
    );

    // Behavioural tag memory with 1-cycle read latency; inj_* lets the bench plant contents directly.
    logic [TW-1:0] mem_tag [NW][NS];
    logic          mem_v   [NW][NS];
    logic          inj_req;
    logic [IW-1:0] inj_idx;
    logic [NW-1:0] inj_ways;
    logic [TW-1:0] inj_tag;

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < NW; w++) mem_v[w][s] <= 1'b0;
        end else if (inj_req) begin
            for (int w = 0; w < NW; w++)
                if (inj_ways[w]) begin
                    mem_tag[w][inj_idx] <= inj_tag;
                    mem_v[w][inj_idx]   <= 1'b1;
                end
        end else if (tm_flush) begin
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < NW; w++) mem_v[w][s] <= 1'b0;
        end else if (|tm_req) begin
            for (int w = 0; w < NW; w++) begin
                if (tm_we) begin
                    if (tm_req[w]) begin
                        mem_tag[w][tm_addr] <= tm_data;
                        mem_v[w][tm_addr]   <= tm_vbit;
                    end
                end else begin
                    rd_tag[w*TW +: TW] <= mem_tag[w][tm_addr];
                    rd_v[w]            <= mem_v[w][tm_addr];
                end
            end
        end
    end

    // Reference model: what each set holds, plus the global round-robin pointer.
    logic [TW-1:0] m_tag [NW][NS];
    bit            m_v   [NW][NS];
    int            m_rr;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] model_hits(input int idx, input logic [TW-1:0] tag);
        logic [NW-1:0] h;
        h = '0;
        for (int w = 0; w < NW; w++) h[w] = m_v[w][idx] && (m_tag[w][idx] == tag);
        return h;
    endfunction

    function automatic int count_ones(input logic [NW-1:0] v);
        int c;
        c = 0;
        for (int w = 0; w < NW; w++) c += int'(v[w]);
        return c;
    endfunction

    task automatic model_flush();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) m_v[w][s] = 1'b0;
        m_rr = 0;
    endtask

    task automatic do_lookup(input int idx, input logic [TW-1:0] tag);
        logic [NW-1:0] eh;
        int n;
        eh = model_hits(idx, tag);
        lkp_valid = 1'b1; lkp_idx = IW'(idx); lkp_tag = tag;
        #1;
        n = 0;
        while (!lkp_ready && n < 20) begin @(negedge clk); #1; n++; end
        chk("lkp_ready", lkp_ready, 1);
        chk("lkp_rd_req", tm_req, 4'hf);
        chk("lkp_rd_addr", tm_addr, idx);
        @(negedge clk);
        lkp_valid = 1'b0;
        chk("resp_valid", resp_valid, 1);
        chk("resp_hit", resp_hit, |eh);
        chk("resp_way", resp_way, eh);
        chk("resp_multi", resp_multi, count_ones(eh) > 1);
    endtask

    task automatic do_refill(input int idx, input logic [TW-1:0] tag, input bit flush_mid);
        logic [NW-1:0] ew;
        int n;
        ew = '0;
        for (int w = 0; w < NW; w++)
            if (!m_v[w][idx] && ew == '0) ew = NW'(1) << w;
        if (ew == '0) begin
            ew   = NW'(1) << m_rr;
            m_rr = (m_rr + 1) % NW;
        end
        for (int w = 0; w < NW; w++)
            if (ew[w]) begin m_tag[w][idx] = tag; m_v[w][idx] = 1'b1; end
        ref_valid = 1'b1; ref_idx = IW'(idx); ref_tag = tag;
        #1;
        n = 0;
        while (!ref_ready && n < 20) begin @(negedge clk); #1; n++; end
        chk("ref_ready", ref_ready, 1);
        @(negedge clk);
        ref_valid = 1'b0;
        chk("ref_rd_req", tm_req, 4'hf);
        chk("ref_rd_addr", tm_addr, idx);
        @(negedge clk);
        if (flush_mid) flush = 1'b1;
        chk("ref_sel_nodone", ref_done, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("ref_done", ref_done, 1);
        chk("ref_way", ref_way, ew);
        chk("ref_wr_req", tm_req, ew);
        chk("ref_wr_we", {tm_we, tm_vbit}, 2'b11);
        chk("ref_wr_data", tm_data, tag);
        chk("ref_wr_flush", tm_flush, 0);
        @(negedge clk);
        chk("ref_done_pulse", ref_done, 0);
    endtask

    task automatic wait_flush(output int lat);
        int n;
        n = 0;
        while (!tm_flush && n < 10) begin @(negedge clk); n++; end
        lat = n;
        chk("flush_seen", tm_flush, 1);
        @(negedge clk);
        chk("flush_done", flush_done, 1);
        chk("flush_one_cycle", tm_flush, 0);
        @(negedge clk);
        chk("flush_done_pulse", flush_done, 0);
        model_flush();
    endtask

    initial begin
        int lat;
        logic [NW-1:0] eh [4];
        int bidx [4];
        logic [TW-1:0] btag [4];

        rst = 1'b1; lkp_valid = 1'b1; ref_valid = 1'b1; flush = 1'b0; inj_req = 1'b0;
        lkp_idx = '0; lkp_tag = '0; ref_idx = '0; ref_tag = '0;
        inj_idx = '0; inj_ways = '0; inj_tag = '0;
        model_flush();
        repeat (3) @(negedge clk);
        chk("rst_lkp_ready", lkp_ready, 0);
        chk("rst_ref_ready", ref_ready, 0);
        chk("rst_tm_req", tm_req, 0);
        chk("rst_outputs", {resp_valid, ref_done, flush_done, tm_flush, tm_we}, 0);
        lkp_valid = 1'b0; ref_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("idle_ref_ready", ref_ready, 1);
        chk("idle_resp_valid", resp_valid, 0);

        // Empty set fill, hit and miss.
        do_refill(5, 20'hA3, 1'b0);
        do_lookup(5, 20'hA3);
        do_lookup(5, 20'hA4);

        // Full set: round-robin victim starts at way 0.
        for (int t = 0; t < 4; t++) do_refill(2, 20'h10 + TW'(t), 1'b0);
        do_refill(2, 20'h55, 1'b0);
        do_lookup(2, 20'h55);
        do_lookup(2, 20'h10);

        // Flush requested mid-refill waits for the write, then runs.
        do_refill(7, 20'h99, 1'b1);
        chk("pend_blocks_ready", ref_ready, 0);
        wait_flush(lat);
        chk("flush_latency", lat, 1);
        do_lookup(5, 20'hA3);

        // Back-to-back lookups.
        do_refill(5, 20'hA3, 1'b0);
        bidx = '{5, 5, 2, 5};
        btag = '{20'hA3, 20'hA4, 20'h55, 20'hA3};
        for (int k = 0; k < 4; k++) eh[k] = model_hits(bidx[k], btag[k]);
        for (int k = 0; k < 4; k++) begin
            lkp_valid = 1'b1; lkp_idx = IW'(bidx[k]); lkp_tag = btag[k];
            #1;
            chk("b2b_ready", lkp_ready, 1);
            if (k > 0) begin
                chk("b2b_valid", resp_valid, 1);
                chk("b2b_way", resp_way, eh[k-1]);
            end
            @(negedge clk);
        end
        lkp_valid = 1'b0;
        chk("b2b_valid", resp_valid, 1);
        chk("b2b_way", resp_way, eh[3]);

        // Duplicate tag planted in ways 1 and 2.
        inj_req = 1'b1; inj_idx = 6'd9; inj_ways = 4'b0110; inj_tag = 20'h7;
        m_tag[1][9] = 20'h7; m_v[1][9] = 1'b1;
        m_tag[2][9] = 20'h7; m_v[2][9] = 1'b1;
        @(negedge clk);
        inj_req = 1'b0;
        do_lookup(9, 20'h7);
        chk("dup_way_literal", resp_way, 4'b0110);

        // Randomized traffic against the model.
        for (int i = 0; i < 120; i++) begin
            int op, idx;
            logic [TW-1:0] tag;
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, 3);
            tag = 20'h100 + TW'($urandom_range(0, 5));
            if (op < 6) do_lookup(idx, tag);
            else if (op < 9) do_refill(idx, tag, 1'b0);
            else begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                wait_flush(lat);
            end
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

endmodule
